i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//   I2C controller (bus master) for the ESC register interface: issues single-byte register writes and
//   reads to a 7-bit-addressed target over open-drain SDA/SCL. Sits in the bench/host-side harness
//   (or a companion tile) and drives the same scl/sda_in/sda_out/sda_oe pins the ESC target consumes.
//   No clock stretching, single master, no arbitration.
// PARAMETERS
//   CLK_DIV   4   clk cycles per SCL quarter-bit; SCL period = 4*CLK_DIV clks; legal range >= 4
// PORTS
//   clk        in   1  system clock; one clock domain
//   rst        in   1  asynchronous, active-high reset
//   cmd_valid  in   1  command request
//   cmd_ready  out  1  high when idle; command accepted on cmd_valid & cmd_ready
//   cmd_rw     in   1  0 = register write, 1 = register read
//   cmd_addr   in   7  target device address
//   cmd_reg    in   8  register index
//   cmd_wdata  in   8  write data; ignored for reads
//   rsp_valid  out  1  one-cycle pulse when transaction ends
//   rsp_nack   out  1  valid with rsp_valid: 1 = target NACKed some byte, transaction aborted
//   rsp_rdata  out  8  valid with rsp_valid: read byte; 0 for writes and aborts
//   busy       out  1  high from accept to rsp_valid, inclusive
//   scl_oe     out  1  1 = pull SCL low; 0 = release (pull-up makes it high)
//   sda_in     in   1  SDA pad value, asynchronous; 2-flop synchronized before use
//   sda_out    out  1  tied 0 (open drain)
//   sda_oe     out  1  1 = pull SDA low; 0 = release
// BEHAVIOUR
// - Reset: scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_rdata=0, FSM IDLE.
//   rst asserted mid-transaction releases both lines on the next edge of rst (async); no STOP is sent.
// - Accept: cmd_* fields latched on the accepting cycle. cmd_ready falls the next cycle.
//   cmd_valid while busy is ignored.
// - Slot timing: every slot is 4 quarters Q0..Q3 of CLK_DIV clks each. A quarter counter and a
//   quarter index drive all FSM steps.
// - Data bit slot (TX): Q0 SCL low, SDA set to bit (oe = ~bit); Q1,Q2 SCL released; Q3 SCL low.
// - RX/ACK slot: SDA released, same SCL pattern. Synchronized sda_in is sampled on the last clk of Q2.
// - START: SDA released Q0-Q1, pulled low Q2-Q3, SCL released Q0-Q2, pulled low Q3.
// - REPEATED START: Q0 SCL low, SDA released; Q1 SCL released; Q2 SDA low; Q3 SCL low.
// - STOP: Q0 SCL low, SDA low; Q1 SCL released; Q2-Q3 SDA released. Bus is left idle (both released).
// - FSM: IDLE -> START -> TX_BYTE(addr,W) -> ACK -> TX_BYTE(reg) -> ACK.
//   Write path: -> TX_BYTE(wdata) -> ACK -> STOP -> DONE.
//   Read path: -> RSTART -> TX_BYTE(addr,R) -> ACK -> RX_BYTE -> MNACK (master drives NACK = SDA
//   released) -> STOP -> DONE.
//   DONE pulses rsp_valid for 1 cycle and returns to IDLE. cmd_ready=1 the following cycle.
// - Bytes are shifted MSB first. The address byte is {addr,rw}: 0 for the first phase, 1 after RSTART.
// - ACK check: sampled SDA=0 is ACK. SDA=1 on any ACK slot sets the nack flag, goes directly to STOP,
//   and DONE reports rsp_nack=1, rsp_rdata=0.
// - Latency from accept to rsp_valid: write = 29 slots*4*CLK_DIV + 1 clk; read = 39 slots*4*CLK_DIV + 1
//   clk; write NACK on address = 11 slots*4*CLK_DIV + 1 clk. (START and STOP are 1 slot each; each
//   byte+ack is 9 slots.)
// - rsp_nack/rsp_rdata hold their value until the next rsp_valid.
// - busy equals ~cmd_ready.
// - scl_oe never toggles inside a quarter. SDA changes only while SCL is low, except START/RSTART/STOP.
// TESTING
// - CLK_DIV=4, target model ACKs; write addr 0x2A reg 0x01 data 0x5C -> bus bytes 0x54,0x01,0x5C; STOP;
//   rsp_valid exactly 465 clks after accept; rsp_nack=0.
// - Read addr 0x2A reg 0x03, target returns 0xA7 -> bytes 0x54,0x03, RSTART, 0x55; rx 0xA7; master
//   NACK; rsp_rdata=0xA7 at clk 625.
// - Target absent (SDA pulled up) -> NACK after address byte, STOP issued, rsp_nack=1, rsp_rdata=0,
//   rsp_valid at clk 177.
// - cmd_valid held high through a transaction -> exactly one accept; second accept on first cycle
//   cmd_ready returns.
// - Assert rst mid data byte -> scl_oe=0, sda_oe=0 asynchronously; post-reset write completes normally.
// - Protocol monitor over all tests: SDA stable while SCL high except START/STOP edges; SCL high and low
//   each >= 2*CLK_DIV clks.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one register write or register read per command on open-drain SCL/SDA.
// Every bus slot is four quarters of CLK_DIV clocks; pin drives decode from the state and quarter index.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic       rsp_nack,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);
    // state   | meaning
    // IDLE    | bus released, waiting for a command
    // START   | start condition slot
    // TX_BYTE | one data bit slot per bit, MSB first, from r_shift
    // ACK     | target acknowledge slot
    // RSTART  | repeated start before the read address
    // RX_BYTE | one received bit slot per bit
    // MNACK   | master releases SDA to end the read
    // STOP    | stop condition slot
    // DONE    | one-cycle response pulse
    localparam int QW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TX_BYTE, S_ACK, S_RSTART, S_RX_BYTE, S_MNACK, S_STOP, S_DONE
    } state_t;

    state_t        r_state, w_next;
    logic [QW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bcnt;
    logic [1:0]    r_phase;
    logic [7:0]    r_shift;
    logic          r_rw, r_nack;
    logic [6:0]    r_addr;
    logic [7:0]    r_reg, r_wdata;
    logic          r_sda_meta, r_sda_sync;
    logic          r_rsp_nack;
    logic [7:0]    r_rsp_rdata;
    logic          w_q_end, w_slot_end, w_sample, w_scl_low;

    assign w_q_end    = (r_qcnt == '0);
    assign w_slot_end = w_q_end && (r_q == 2'd3);
    assign w_sample   = w_q_end && (r_q == 2'd2);
    assign w_scl_low  = (r_q == 2'd0) || (r_q == 2'd3);

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (r_state == S_DONE);
    assign rsp_nack  = r_rsp_nack;
    assign rsp_rdata = r_rsp_rdata;
    assign sda_out   = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (r_state)
            S_IDLE:    if (cmd_valid) w_next = S_START;
            S_START: begin
                scl_oe = (r_q == 2'd3);
                sda_oe = r_q[1];
                if (w_slot_end) w_next = S_TX_BYTE;
            end
            S_TX_BYTE: begin
                scl_oe = w_scl_low;
                sda_oe = ~r_shift[7];
                if (w_slot_end && r_bcnt == 3'd0) w_next = S_ACK;
            end
            S_ACK: begin
                scl_oe = w_scl_low;
                if (w_slot_end) begin
                    if (r_nack) w_next = S_STOP;
                    else begin
                        case (r_phase)
                            2'd0:    w_next = S_TX_BYTE;
                            2'd1:    w_next = r_rw ? S_RSTART : S_TX_BYTE;
                            2'd2:    w_next = S_STOP;
                            default: w_next = S_RX_BYTE;
                        endcase
                    end
                end
            end
            S_RSTART: begin
                scl_oe = w_scl_low;
                sda_oe = r_q[1];
                if (w_slot_end) w_next = S_TX_BYTE;
            end
            S_RX_BYTE: begin
                scl_oe = w_scl_low;
                if (w_slot_end && r_bcnt == 3'd0) w_next = S_MNACK;
            end
            S_MNACK: begin
                scl_oe = w_scl_low;
                if (w_slot_end) w_next = S_STOP;
            end
            S_STOP: begin
                scl_oe = (r_q == 2'd0);
                sda_oe = ~r_q[1];
                if (w_slot_end) w_next = S_DONE;
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Quarter timer parks at its reload value outside a transaction so START gets a full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qcnt <= QW'(CLK_DIV - 1);
            r_q    <= 2'd0;
        end else if (r_state == S_IDLE || r_state == S_DONE) begin
            r_qcnt <= QW'(CLK_DIV - 1);
            r_q    <= 2'd0;
        end else if (w_q_end) begin
            r_qcnt <= QW'(CLK_DIV - 1);
            r_q    <= r_q + 2'd1;
        end else begin
            r_qcnt <= r_qcnt - QW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw    <= 1'b0;
            r_addr  <= 7'd0;
            r_reg   <= 8'd0;
            r_wdata <= 8'd0;
            r_phase <= 2'd0;
            r_nack  <= 1'b0;
            r_shift <= 8'd0;
            r_bcnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_rw    <= cmd_rw;
                    r_addr  <= cmd_addr;
                    r_reg   <= cmd_reg;
                    r_wdata <= cmd_wdata;
                    r_phase <= 2'd0;
                    r_nack  <= 1'b0;
                    r_shift <= {cmd_addr, 1'b0};
                    r_bcnt  <= 3'd7;
                end
                S_TX_BYTE: if (w_slot_end && r_bcnt != 3'd0) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_bcnt  <= r_bcnt - 3'd1;
                end
                S_ACK: begin
                    if (w_sample) r_nack <= r_sda_sync;
                    if (w_slot_end && !r_nack) begin
                        r_bcnt <= 3'd7;
                        case (r_phase)
                            2'd0: begin
                                r_shift <= r_reg;
                                r_phase <= 2'd1;
                            end
                            2'd1: begin
                                r_shift <= r_rw ? {r_addr, 1'b1} : r_wdata;
                                r_phase <= r_rw ? 2'd3 : 2'd2;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RX_BYTE: begin
                    if (w_sample) r_shift <= {r_shift[6:0], r_sda_sync};
                    if (w_slot_end && r_bcnt != 3'd0) r_bcnt <= r_bcnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_nack  <= 1'b0;
            r_rsp_rdata <= 8'd0;
        end else if (r_state == S_STOP && w_slot_end) begin
            r_rsp_nack  <= r_nack;
            r_rsp_rdata <= (r_rw && !r_nack) ? r_shift : 8'd0;
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C target on the pins, transaction-level reference model,
// directed cases plus randomized register writes/reads with address misses and register NACKs.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
    localparam logic [6:0] TADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_reg, cmd_wdata;
    logic       rsp_valid, rsp_nack;
    logic [7:0] rsp_rdata;
    logic       busy, scl_oe, sda_in, sda_out, sda_oe;

    logic       tgt_pull;
    logic       b_scl, b_sda;
    assign b_scl  = ~scl_oe;
    assign b_sda  = ~(sda_oe | tgt_pull);
    assign sda_in = b_sda;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .busy(busy), .scl_oe(scl_oe), .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // target configuration, written only by the stimulus process
    bit         present = 1'b1;
    bit         nack_reg = 1'b0;
    logic [7:0] tdata = 8'h00;

    // target / monitor state, written only by the target process
    logic [7:0] bytes[$];
    int         n_start = 0, n_stop = 0, n_viol = 0, run = 1000, bitn = 0, bidx = 0, mode = 0;
    int         cyc = 0, n_acc = 0;
    logic       p_scl = 1'b1, p_sda = 1'b1, mack = 1'b0, rd_pend = 1'b0;
    logic [7:0] sh = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready && !rst) n_acc <= n_acc + 1;
    end

    // Target: mode 0 idle, 1 receiving, 2 sending read data.
    always @(posedge clk) begin
        if (rst) begin
            tgt_pull <= 1'b0;
            mode = 0; bitn = 0; rd_pend = 1'b0;
            p_scl = 1'b1; p_sda = 1'b1; run = 1000;
        end else begin
            if (b_scl != p_scl) begin
                if (run < 2 * CLK_DIV) n_viol++;
                run = 1;
            end else if (run < 1000) run++;
            if (b_scl && p_scl && p_sda && !b_sda) begin
                n_start++; mode = 1; bitn = 0; bidx = 0; tgt_pull <= 1'b0;
            end else if (b_scl && p_scl && !p_sda && b_sda) begin
                n_stop++; mode = 0; tgt_pull <= 1'b0;
            end else if (b_scl && !p_scl) begin
                if (bitn < 8) sh = {sh[6:0], b_sda};
                else if (bitn == 8 && mode == 2) mack = b_sda;
                bitn++;
            end else if (!b_scl && p_scl) begin
                if (mode == 1 && bitn == 8) begin
                    bit ack;
                    bytes.push_back(sh);
                    ack = present && ((bidx == 0) ? (sh[7:1] == TADDR) : !(bidx == 1 && nack_reg));
                    tgt_pull <= ack;
                    if (!ack) mode = 0;
                    else if (bidx == 0 && sh[0]) rd_pend = 1'b1;
                    bidx++;
                end else if (bitn == 9) begin
                    bitn = 0;
                    tgt_pull <= 1'b0;
                    if (mode == 1 && rd_pend) begin
                        mode = 2; rd_pend = 1'b0; tgt_pull <= ~tdata[7];
                    end else if (mode == 2) mode = 0;
                end else if (mode == 2 && bitn >= 1 && bitn <= 7) begin
                    tgt_pull <= ~tdata[7 - bitn];
                end else if (mode == 2 && bitn == 8) begin
                    tgt_pull <= 1'b0;
                end
            end
            p_scl = b_scl; p_sda = b_sda;
        end
    end

    // Reference model: expected bus bytes and response from the transaction rules.
    logic [7:0] exp_q[$];
    int         e_lat, e_starts, t_acc, b_base, s_base, p_base;
    bit         e_nack, e_rd_ok;
    logic [7:0] e_rdata;

    task automatic model(input bit rw, input logic [6:0] a, input logic [7:0] r, input logic [7:0] wd);
        int k;
        int slots;
        exp_q.delete();
        exp_q.push_back({a, 1'b0});
        if (!(present && a == TADDR)) k = 1;
        else begin
            exp_q.push_back(r);
            if (nack_reg) k = 2;
            else begin
                k = 0;
                exp_q.push_back(rw ? {a, 1'b1} : wd);
            end
        end
        if (k != 0)  slots = 1 + 9 * k + 1;
        else if (!rw) slots = 1 + 3 * 9 + 1;
        else          slots = 1 + 2 * 9 + 1 + 9 + 8 + 1 + 1;
        e_lat    = slots * 4 * CLK_DIV + 1;
        e_nack   = (k != 0);
        e_rd_ok  = rw && (k == 0);
        e_rdata  = e_rd_ok ? tdata : 8'h00;
        e_starts = e_rd_ok ? 2 : 1;
    endtask

    task automatic start_cmd(input bit rw, input logic [6:0] a, input logic [7:0] r,
                             input logic [7:0] wd, input bit hold);
        int n = 0;
        model(rw, a, r, wd);
        b_base = bytes.size(); s_base = n_start; p_base = n_stop;
        cmd_rw = rw; cmd_addr = a; cmd_reg = r; cmd_wdata = wd; cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", cmd_ready, 1);
        t_acc = cyc;
        @(negedge clk);
        chk("ready_fall", cmd_ready, 0);
        chk("busy_rise", busy, 1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(output int lat);
        int n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        chk("rsp_timeout", rsp_valid, 1);
        lat = cyc - t_acc;
        chk("latency", lat, e_lat);
        chk("rsp_nack", rsp_nack, e_nack);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("busy_done", busy, 1);
        chk("bus_idle_scl", scl_oe, 0);
        chk("bus_idle_sda", sda_oe, 0);
        chk("nbytes", bytes.size() - b_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && b_base + i < bytes.size(); i++)
            chk("bus_byte", bytes[b_base + i], exp_q[i]);
        chk("starts", n_start - s_base, e_starts);
        chk("stops", n_stop - p_base, 1);
        if (e_rd_ok) chk("master_nack", mack, 1);
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("ready_back", cmd_ready, 1);
        chk("hold_nack", rsp_nack, e_nack);
        chk("hold_rdata", rsp_rdata, e_rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int acc0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'd0; cmd_reg = 8'd0; cmd_wdata = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl_oe, 0);
        chk("rst_sda", sda_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("sda_out_tied", sda_out, 0);

        start_cmd(1'b0, 7'h2A, 8'h01, 8'h5C, 1'b0);
        finish_cmd(lat);
        chk("wr_lat_465", lat, 465);

        tdata = 8'hA7;
        start_cmd(1'b1, 7'h2A, 8'h03, 8'h00, 1'b0);
        finish_cmd(lat);
        chk("rd_lat_625", lat, 625);
        chk("rd_data_a7", rsp_rdata, 8'hA7);

        present = 1'b0;
        start_cmd(1'b0, 7'h2A, 8'h01, 8'h5C, 1'b0);
        finish_cmd(lat);
        chk("absent_lat_177", lat, 177);
        present = 1'b1;

        acc0 = n_acc;
        start_cmd(1'b0, 7'h2A, 8'h22, 8'h33, 1'b1);
        finish_cmd(lat);
        chk("one_accept", n_acc - acc0, 1);
        start_cmd(1'b0, 7'h2A, 8'h22, 8'h33, 1'b0);
        chk("second_accept", n_acc - acc0, 2);
        finish_cmd(lat);

        start_cmd(1'b0, 7'h2A, 8'h10, 8'h00, 1'b0);
        repeat (21 * 4 * CLK_DIV) @(negedge clk);
        n = 0;
        while (!(scl_oe && sda_oe) && n < 4 * CLK_DIV) begin @(negedge clk); n++; end
        chk("pre_rst_driving", {scl_oe, sda_oe}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_scl", scl_oe, 0);
        chk("async_rst_sda", sda_oe, 0);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_cmd(1'b0, 7'h2A, 8'h44, 8'hC3, 1'b0);
        finish_cmd(lat);

        for (int i = 0; i < 10; i++) begin
            bit         rw;
            logic [6:0] a;
            rw       = 1'($urandom_range(0, 1));
            a        = ($urandom_range(0, 3) != 0) ? TADDR : 7'($urandom);
            tdata    = 8'($urandom);
            nack_reg = ($urandom_range(0, 4) == 0);
            start_cmd(rw, a, 8'($urandom), 8'($urandom), 1'b0);
            finish_cmd(lat);
        end
        nack_reg = 1'b0;

        chk("scl_pulse_width", n_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
